datamem_bank: RTL and testbench
===============================

Name: datamem_bank

Overview:
Parametrised single-port data memory bank for the CPU data path. It is the next generation of the data memory section. It adds:
- a valid/ready request handshake
- per-byte write enables
- selectable read latency
- out-of-range detection
- a hardware clear sweep after reset

It sits between the load/store unit and on-chip RAM, and replaces the fixed 32-bit, 1-cycle memory.

Parameters:
DATA_W, 32, word width in bits; multiple of 8
ADDR_W, 16, word-address width
DEPTH, 1024, words implemented; must be ≤ 2**ADDR_W
RD_LAT, 1, response latency in cycles after acceptance; legal values 1 or 2
CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting requests

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  bank can accept a request this cycle
req_wren  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_data  in  DATA_W  write data
req_be  in  DATA_W/8  byte enables; bit i covers req_data[8i+7:8i]
rsp_valid  out  1  response strobe, one cycle wide
rsp_data  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  address ≥ DEPTH, qualified by rsp_valid
init_busy  out  1  clear sweep in progress

Behaviour:
- Reset (reset_n low, asynchronous):
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0.
  - Response pipeline flushed; clear counter=0.
  - State = CLEAR if CLEAR_ON_RESET, else READY.
  - init_busy=1 during reset when CLEAR_ON_RESET=1.
  - RAM contents are not reset asynchronously.
- FSM states: CLEAR, READY.
  - CLEAR: writes 0 to address clear_cnt with all bytes enabled, one word per cycle, clear_cnt++. After writing DEPTH-1, go to READY. CLEAR lasts exactly DEPTH cycles after reset release.
  - READY: terminal state until the next reset.
- Outputs by state:
  - req_ready = (state==READY); registered, no combinational path from req_valid.
  - init_busy = (state==CLEAR).
- Acceptance: req_valid && req_ready. At most one request per cycle. req_valid while not ready is ignored, not queued.
- Accepted write, address < DEPTH: updates only the bytes with req_be set, at the accepting clock edge. req_be=0 is a legal no-op write.
- Accepted read, address < DEPTH: returns the word as of that edge.
  - A read accepted the cycle after a write to the same address returns the new data.
- Out of range (address ≥ DEPTH): RAM untouched; the response has rsp_err=1 and rsp_data=0.
- Every accepted request, read or write, produces exactly one response. rsp_valid pulses exactly RD_LAT cycles after acceptance. Responses come in acceptance order.
- Write responses carry rsp_data=0 and rsp_err=0, or rsp_err=1 if out of range.
- No response back-pressure; the consumer must always sample rsp_* when rsp_valid=1.
- Back-to-back requests give back-to-back responses at full throughput for either RD_LAT.
- RD_LAT=2 adds one output register stage after the RAM read register.
- rsp_data and rsp_err hold their last values while rsp_valid=0.
- Reset mid-operation:
  - In-flight responses are dropped; rsp_valid never pulses for requests accepted before reset.
  - With CLEAR_ON_RESET=1 the clear restarts from address 0.
- Parameter checks: illegal RD_LAT, DEPTH > 2**ADDR_W, or DATA_W%8≠0 give an elaboration-time $error.

Decomposition:
- Package datamem_pkg:
  - state enum {CLEAR, READY}
  - localparam BE_W = DATA_W/8 helper function
  - latency legality constants
- Sub-module datamem_ram: byte-enabled synchronous single-port array, 1-cycle registered read, no reset.
- datamem_bank owns the FSM, clear counter, range check, response pipeline, and the mux between the clear port and the request port.

Test Plan:
1. Reset release, CLEAR_ON_RESET=1, DEPTH=16 → init_busy=1 and req_ready=0 for exactly 16 cycles, then req_ready=1; reading addresses 0..15 returns 0 with rsp_err=0.
2. Write data=addr to addresses 0..15 with be=4'hF, then read 0..15 back-to-back, RD_LAT=1 → rsp_data=0..15 in order, each rsp_valid exactly 1 cycle after acceptance; repeat with RD_LAT=2 at 2-cycle latency.
3. Write 32'hAABBCCDD to addr 5, then write 32'h11223344 to addr 5 with be=4'b0101 → read of addr 5 returns 32'hAA22CC44.
4. Read addr 20 with DEPTH=16 → rsp_err=1, rsp_data=0; write to addr 20, then read addr 4 (20 mod 16) → addr 4 unchanged.
5. Write addr 3 = 32'h5A5A5A5A, then read addr 3 on the next cycle → 32'h5A5A5A5A.
6. Accept reads at addrs 1 and 2, assert reset_n=0 one cycle later → no rsp_valid pulses for those reads; after release the clear re-runs (16 cycles) and addr 1 reads 0.

Source files
------------

// File: rtl/datamem_bank_pkg.sv
// rtl/datamem_bank_pkg.sv - shared state encoding, widths and latency limits for the data memory bank
package datamem_bank_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

  function automatic bit rd_lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/datamem_bank_if.sv
// rtl/datamem_bank_if.sv - request/response bus between the load/store unit and the data memory bank
interface datamem_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  import datamem_bank_pkg::*;

  localparam int BE_W = be_width(DATA_W);

  logic              req_valid;
  logic              req_ready;
  logic              req_wren;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_wren, req_addr, req_data, req_be,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_wren, req_addr, req_data, req_be,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/datamem_bank_ram.sv
// rtl/datamem_bank_ram.sv - byte-enabled single-port array with a registered read, no reset
module datamem_bank_ram
  import datamem_bank_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic [be_width(DATA_W)-1:0] be_i,
  input  logic [AW-1:0]             addr_i,
  input  logic [DATA_W-1:0]         wdata_i,
  output logic [DATA_W-1:0]         rdata_o
);

  localparam int BE_W = be_width(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/datamem_bank.sv
// rtl/datamem_bank.sv - data memory bank: clear sweep FSM, range check and fixed-latency response pipeline
module datamem_bank
  import datamem_bank_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 16,
  parameter int DEPTH          = 1024,
  parameter int RD_LAT         = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic           clock_i,
  input  logic           reset_n_i,
  datamem_bank_if.slave  bus_if,
  output logic           init_busy_o
);

  localparam int              BE_W    = be_width(DATA_W);
  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [0:0]      S_CLEAR = ST_CLEAR;
  localparam logic [0:0]      S_READY = ST_READY;
  localparam logic [0:0]      S_RESET = CLEAR_ON_RESET ? S_CLEAR : S_READY;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [AW-1:0]   LAST_A  = AW'(DEPTH - 1);

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_lat
    $error("datamem_bank: RD_LAT must be 1 or 2");
  end
  if (longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
    $error("datamem_bank: DEPTH exceeds the address space");
  end
  if ((DATA_W % 8) != 0) begin : g_bad_width
    $error("datamem_bank: DATA_W must be a multiple of 8");
  end

  logic [0:0]        state_q, state_d;
  logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
  logic              ready_q;
  logic              accept, in_range;
  logic              ram_we;
  logic [BE_W-1:0]   ram_be;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata, s1_data;
  logic              p1_valid_q, p1_err_q, p1_rd_q;
  logic [DATA_W-1:0] hold_data_q;
  logic              hold_err_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == S_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST_A) begin
        state_d   = S_READY;
        clr_cnt_d = '0;
      end
    end
  end

  // ready follows the next state so it rises on the same edge the sweep ends
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_RESET;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= (state_d == S_READY);
    end
  end

  assign accept   = bus_if.req_valid && ready_q;
  assign in_range = {1'b0, bus_if.req_addr} < DEPTH_L;

  always_comb begin
    if (state_q == S_CLEAR) begin
      ram_we    = 1'b1;
      ram_be    = '1;
      ram_addr  = clr_cnt_q;
      ram_wdata = '0;
    end else begin
      ram_we    = accept && bus_if.req_wren && in_range;
      ram_be    = bus_if.req_be;
      ram_addr  = bus_if.req_addr[AW-1:0];
      ram_wdata = bus_if.req_data;
    end
  end

  datamem_bank_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk_i   (clock_i),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // stage 1 lines up with the RAM read register; the hold registers double as the second stage
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      p1_valid_q  <= 1'b0;
      p1_err_q    <= 1'b0;
      p1_rd_q     <= 1'b0;
      hold_data_q <= '0;
      hold_err_q  <= 1'b0;
    end else begin
      p1_valid_q <= accept;
      p1_err_q   <= accept && !in_range;
      p1_rd_q    <= accept && !bus_if.req_wren && in_range;
      if (p1_valid_q) begin
        hold_data_q <= s1_data;
        hold_err_q  <= p1_err_q;
      end
    end
  end

  assign s1_data = p1_rd_q ? ram_rdata : '0;

  if (RD_LAT == 2) begin : g_lat2
    logic p2_valid_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        p2_valid_q <= 1'b0;
      end else begin
        p2_valid_q <= p1_valid_q;
      end
    end

    assign bus_if.rsp_valid = p2_valid_q;
    assign bus_if.rsp_data  = hold_data_q;
    assign bus_if.rsp_err   = hold_err_q;
  end else begin : g_lat1
    assign bus_if.rsp_valid = p1_valid_q;
    assign bus_if.rsp_data  = p1_valid_q ? s1_data : hold_data_q;
    assign bus_if.rsp_err   = p1_valid_q ? p1_err_q : hold_err_q;
  end

  assign bus_if.req_ready = ready_q;
  assign init_busy_o      = (state_q == S_CLEAR);

endmodule

// File: tb/tb_datamem_bank.sv
// tb/tb_datamem_bank.sv - directed and randomized check of datamem_bank at read latency 1 and 2
module tb_datamem_bank;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 16;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic          clk       = 1'b0;
  logic          reset_n   = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_wren  = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_data  = '0;
  logic [3:0]    req_be    = '0;
  logic          busy1, busy2;

  int          checks    = 0;
  int          failures  = 0;
  int          cyc       = 0;
  int          since_rel = 0;
  logic [31:0] model_mem [DEPTH];
  rsp_t        exp_q [2][$];
  logic [31:0] last_d [2];
  logic        last_e [2];

  always #5 clk = ~clk;

  datamem_bank_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();
  datamem_bank_if #(.DATA_W(DW), .ADDR_W(AW)) if2 ();

  assign if1.req_valid = req_valid;
  assign if1.req_wren  = req_wren;
  assign if1.req_addr  = req_addr;
  assign if1.req_data  = req_data;
  assign if1.req_be    = req_be;
  assign if2.req_valid = req_valid;
  assign if2.req_wren  = req_wren;
  assign if2.req_addr  = req_addr;
  assign if2.req_data  = req_data;
  assign if2.req_be    = req_be;

  datamem_bank #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(1), .CLEAR_ON_RESET(1'b1)
  ) dut1 (
    .clock_i(clk), .reset_n_i(reset_n), .bus_if(if1), .init_busy_o(busy1)
  );

  datamem_bank #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(2), .CLEAR_ON_RESET(1'b1)
  ) dut2 (
    .clock_i(clk), .reset_n_i(reset_n), .bus_if(if2), .init_busy_o(busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q[0].delete();
    exp_q[1].delete();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    for (int p = 0; p < 2; p++) begin
      last_d[p] = '0;
      last_e[p] = 1'b0;
    end
  endtask

  // Memory behaviour from the rules: byte-masked writes, in-range reads, errors beyond DEPTH
  task automatic model_accept();
    rsp_t r;
    int   a;
    a      = int'(req_addr);
    r.err  = (a >= DEPTH);
    r.data = '0;
    if (!r.err && !req_wren) r.data = model_mem[a];
    if (!r.err && req_wren) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be[b]) model_mem[a][8*b +: 8] = req_data[8*b +: 8];
      end
    end
    r.due = cyc;
    exp_q[0].push_back(r);
    r.due = cyc + 1;
    exp_q[1].push_back(r);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      since_rel = 0;
    end else begin
      if (req_valid && since_rel >= DEPTH) model_accept();
      since_rel++;
    end
  end

  task automatic check_port(input int p, input logic v, input logic [31:0] d, input logic e,
                            input logic rdy, input logic busy);
    logic exp_rdy;
    exp_rdy = reset_n && (since_rel >= DEPTH);
    check($sformatf("req_ready[%0d] cyc%0d", p, cyc), 32'(rdy), 32'(exp_rdy));
    check($sformatf("init_busy[%0d] cyc%0d", p, cyc), 32'(busy), 32'(!exp_rdy));
    if (exp_q[p].size() > 0 && exp_q[p][0].due == cyc) begin
      rsp_t r;
      r = exp_q[p].pop_front();
      check($sformatf("rsp_valid[%0d] cyc%0d", p, cyc), 32'(v), 32'd1);
      check($sformatf("rsp_data[%0d] cyc%0d", p, cyc), d, r.data);
      check($sformatf("rsp_err[%0d] cyc%0d", p, cyc), 32'(e), 32'(r.err));
      last_d[p] = r.data;
      last_e[p] = r.err;
    end else begin
      check($sformatf("rsp_idle[%0d] cyc%0d", p, cyc), 32'(v), 32'd0);
      check($sformatf("rsp_hold_data[%0d] cyc%0d", p, cyc), d, last_d[p]);
      check($sformatf("rsp_hold_err[%0d] cyc%0d", p, cyc), 32'(e), 32'(last_e[p]));
    end
  endtask

  always @(negedge clk) begin
    check_port(0, if1.rsp_valid, if1.rsp_data, if1.rsp_err, if1.req_ready, busy1);
    check_port(1, if2.rsp_valid, if2.rsp_data, if2.rsp_err, if2.req_ready, busy2);
  end

  task automatic drive(input logic v, input logic w, input int a, input logic [31:0] d,
                       input logic [3:0] be);
    @(negedge clk);
    req_valid = v;
    req_wren  = w;
    req_addr  = AW'(a);
    req_data  = d;
    req_be    = be;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, '0, '0);
  endtask

  initial begin
    model_reset();
    idle(3);
    reset_n = 1'b1;
    idle(DEPTH + 1);

    for (int a = 0; a < DEPTH; a++) drive(1'b1, 1'b0, a, '0, '0);
    for (int a = 0; a < DEPTH; a++) drive(1'b1, 1'b1, a, 32'(a), 4'hF);
    for (int a = 0; a < DEPTH; a++) drive(1'b1, 1'b0, a, '0, '0);
    idle(3);

    drive(1'b1, 1'b1, 5, 32'hAABBCCDD, 4'hF);
    drive(1'b1, 1'b1, 5, 32'h11223344, 4'b0101);
    drive(1'b1, 1'b0, 5, '0, '0);
    drive(1'b1, 1'b0, 20, '0, '0);
    drive(1'b1, 1'b1, 20, 32'hFFFFFFFF, 4'hF);
    drive(1'b1, 1'b0, 4, '0, '0);
    drive(1'b1, 1'b1, 3, 32'h5A5A5A5A, 4'hF);
    drive(1'b1, 1'b0, 3, '0, '0);
    drive(1'b1, 1'b1, 7, 32'h01020304, 4'h0);
    drive(1'b1, 1'b0, 7, '0, '0);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 23)), $urandom, 4'($urandom_range(0, 15)));
    end
    idle(4);

    drive(1'b1, 1'b1, 1, 32'hDEADBEEF, 4'hF);
    drive(1'b1, 1'b0, 1, '0, '0);
    drive(1'b1, 1'b0, 2, '0, '0);
    @(posedge clk);
    #1;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    model_reset();
    idle(3);
    reset_n = 1'b1;
    idle(DEPTH + 1);
    drive(1'b1, 1'b0, 1, '0, '0);
    drive(1'b1, 1'b0, 2, '0, '0);
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
